// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: two-master (inst, data) to one-slave sram-like arbiter.
// An in-order ID FIFO steers each slave response back to the master that
// issued it. Accepts stall while OT_DEPTH requests are outstanding.
// Optional feature: define ARB_ROUND_ROBIN_EN to switch from fixed priority
// (data over inst) to round-robin between the two masters.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_FREE   | owner chosen by arbitration each cycle
// ST_LOCKED | slave saw s_req without s_addr_ok; lock_owner_q keeps the bus
module sram_like_arbiter #(
  parameter int OT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req_i,
  input  logic        inst_wr_i,
  input  logic [1:0]  inst_size_i,
  input  logic [31:0] inst_addr_i,
  input  logic [3:0]  inst_wstrb_i,
  input  logic [31:0] inst_wdata_i,
  output logic        inst_addr_ok_o,
  output logic        inst_data_ok_o,
  output logic [31:0] inst_rdata_o,
  input  logic        data_req_i,
  input  logic        data_wr_i,
  input  logic [1:0]  data_size_i,
  input  logic [31:0] data_addr_i,
  input  logic [3:0]  data_wstrb_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_addr_ok_o,
  output logic        data_data_ok_o,
  output logic [31:0] data_rdata_o,
  output logic        s_req_o,
  output logic        s_wr_o,
  output logic [1:0]  s_size_o,
  output logic [31:0] s_addr_o,
  output logic [3:0]  s_wstrb_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_addr_ok_i,
  input  logic        s_data_ok_i,
  input  logic [31:0] s_rdata_i,
  output logic [3:0]  ot_cnt_o,
  output logic        err_o
);

  localparam int          PW      = $clog2(OT_DEPTH);
  localparam logic [3:0]  DEPTH_C = 4'(OT_DEPTH);

  typedef enum logic {ST_FREE, ST_LOCKED} state_e;

  state_e          state_q, state_d;
  logic            lock_owner_q, lock_owner_d;
  logic [OT_DEPTH-1:0] fifo_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [3:0]      cnt_q, cnt_d;
  logic            err_q;

  logic owner;      // 0 = inst, 1 = data
  logic pref;
  logic held_req;
  logic owner_req;
  logic full, empty;
  logic accept, pop;
  logic head;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;

  // Remember which master was accepted last; the other one gets priority.
  always_ff @(posedge clk) begin
    if (reset)       last_q <= 1'b0;
    else if (accept) last_q <= owner;
  end
`endif

  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == 4'd0);
  assign head  = fifo_q[rd_ptr_q];

  // Owner selection, request mux, handshake steering and lock next-state.
  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    pref         = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    pref         = ~last_q;
`endif
    held_req = lock_owner_q ? data_req_i : inst_req_i;
    // A locked master that drops req releases the bus in that same cycle.
    if (state_q == ST_LOCKED && held_req) owner = lock_owner_q;
    else if (inst_req_i && data_req_i)    owner = pref;
    else if (inst_req_i)                  owner = 1'b0;
    else                                  owner = 1'b1;

    owner_req = owner ? data_req_i : inst_req_i;
    s_req_o   = owner_req & ~full & ~reset;
    s_wr_o    = owner ? data_wr_i    : inst_wr_i;
    s_size_o  = owner ? data_size_i  : inst_size_i;
    s_addr_o  = owner ? data_addr_i  : inst_addr_i;
    s_wstrb_o = owner ? data_wstrb_i : inst_wstrb_i;
    s_wdata_o = owner ? data_wdata_i : inst_wdata_i;

    accept         = s_req_o & s_addr_ok_i;
    inst_addr_ok_o = accept & ~owner;
    data_addr_ok_o = accept & owner;

    pop            = s_data_ok_i & ~empty & ~reset;
    inst_data_ok_o = pop & ~head;
    data_data_ok_o = pop & head;

    if (s_req_o && !s_addr_ok_i) begin
      state_d      = ST_LOCKED;
      lock_owner_d = owner;
    end else begin
      state_d      = ST_FREE;
    end

    cnt_d = cnt_q + 4'(accept) - 4'(pop);
  end

  assign inst_rdata_o = s_rdata_i;
  assign data_rdata_o = s_rdata_i;
  assign ot_cnt_o     = cnt_q;
  assign err_o        = err_q;

  // Lock state, FIFO pointers, outstanding count and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FREE;
      lock_owner_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= 4'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
      cnt_q        <= cnt_d;
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      if (s_data_ok_i && empty) err_q <= 1'b1;
    end
  end

  // ID storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (!reset && accept) fifo_q[wr_ptr_q] <= owner;
  end

endmodule
